// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR stimulus + MISR compaction BIST sequencer for 18-in/10-out gate models.
// Latency: SETTLE+1 cycles per vector; done rises N_PATTERNS*(SETTLE+1) edges after the start edge.
// Backpressure: none; start is ignored while busy, abort always wins and returns to IDLE.
//
// Ports:
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_start           begin a run (honoured only in IDLE or DONE)
//   i_abort           terminate the run, priority over i_start
//   i_exp_sig         golden signature, sampled on the edge that enters DONE
//   i_dut_out         response of the gate model under test
//   o_dut_in          registered stimulus vector to the gate model
//   o_busy            high while a run is in progress (SETTLE/CAPTURE)
//   o_done            level, high in DONE
//   o_pass            signature matched golden; meaningful only while o_done=1
//   o_signature       live MISR contents
//   o_pat_cnt         vectors captured in the current/last run
module gate_bist_ctrl #(
   parameter int unsigned N_PATTERNS = 256,
   parameter int unsigned SETTLE     = 2,
   parameter logic [17:0] LFSR_SEED  = 18'h00001
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [9:0]  i_exp_sig,
   input  logic [9:0]  i_dut_out,
   output logic [17:0] o_dut_in,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [9:0]  o_signature,
   output logic [15:0] o_pat_cnt
);

   generate
      if (SETTLE == 0) begin : g_bad_settle
         $error("gate_bist_ctrl: SETTLE must be at least 1");
      end
      if (N_PATTERNS == 0 || N_PATTERNS > 65535) begin : g_bad_npat
         $error("gate_bist_ctrl: N_PATTERNS must be in 1..65535");
      end
   endgenerate

   // Settle counter only needs to reach SETTLE-1.
   localparam int              SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
   localparam logic [15:0]     N_LAST      = 16'(N_PATTERNS);
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [17:0]     SEED        = (LFSR_SEED == 18'd0) ? 18'h00001 : LFSR_SEED;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          r_state;
   logic [17:0]     r_dut_in;
   logic [9:0]      r_misr;
   logic [15:0]     r_pat_cnt;
   logic [SCW-1:0]  r_settle_cnt;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;

   state_t          w_state_nxt;
   logic [17:0]     w_dut_in_nxt;
   logic [9:0]      w_misr_nxt;
   logic [15:0]     w_pat_cnt_nxt;
   logic [SCW-1:0]  w_settle_nxt;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            w_pass_nxt;

   logic [17:0]     w_lfsr_upd;
   logic [9:0]      w_misr_upd;
   logic [15:0]     w_pat_inc;

   // x^18 + x^11 + 1, shifting toward the MSB
   assign w_lfsr_upd = {r_dut_in[16:0], r_dut_in[17] ^ r_dut_in[10]};
   assign w_pat_inc  = r_pat_cnt + 16'd1;

   // x^10 + x^7 + 1 MISR folding in the current response word
   always_comb begin
      w_misr_upd[0] = r_misr[9] ^ r_misr[6] ^ i_dut_out[0];
      for (int i = 1; i < 10; i++) begin
         w_misr_upd[i] = r_misr[i-1] ^ i_dut_out[i];
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_dut_in_nxt  = r_dut_in;
      w_misr_nxt    = r_misr;
      w_pat_cnt_nxt = r_pat_cnt;
      w_settle_nxt  = r_settle_cnt;
      w_busy_nxt    = r_busy;
      w_done_nxt    = r_done;
      w_pass_nxt    = r_pass;

      if (i_abort) begin
         // signature and pat_cnt are kept so a debugger can see how far the run got
         w_state_nxt  = S_IDLE;
         w_dut_in_nxt = '0;
         w_settle_nxt = '0;
         w_busy_nxt   = 1'b0;
         w_done_nxt   = 1'b0;
         w_pass_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  w_state_nxt   = S_SETTLE;
                  w_dut_in_nxt  = SEED;
                  w_misr_nxt    = '0;
                  w_pat_cnt_nxt = '0;
                  w_settle_nxt  = '0;
                  w_busy_nxt    = 1'b1;
                  w_done_nxt    = 1'b0;
                  w_pass_nxt    = 1'b0;
               end
            end
            S_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  w_settle_nxt = '0;
                  w_state_nxt  = S_CAPTURE;
               end else begin
                  w_settle_nxt = r_settle_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               w_misr_nxt    = w_misr_upd;
               w_pat_cnt_nxt = w_pat_inc;
               if (w_pat_inc == N_LAST) begin
                  // dut_in keeps the last vector for inspection in DONE
                  w_state_nxt = S_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_pass_nxt  = (w_misr_upd == i_exp_sig);
               end else begin
                  w_dut_in_nxt = w_lfsr_upd;
                  w_state_nxt  = S_SETTLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_dut_in     <= '0;
         r_misr       <= '0;
         r_pat_cnt    <= '0;
         r_settle_cnt <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_dut_in     <= w_dut_in_nxt;
         r_misr       <= w_misr_nxt;
         r_pat_cnt    <= w_pat_cnt_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_pass       <= w_pass_nxt;
      end
   end

   assign o_dut_in    = r_dut_in;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_signature = r_misr;
   assign o_pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: bench for gate_bist_ctrl across four parameter sets.
// Instances: 0 (N=12,S=1), 1 (N=1,S=1), 2 (N=3,S=1), 3 (N=40,S=3,seed 0, keyed gate model).
// Expected done records and vector streams are queued at stimulus time and popped by monitors.
module tb_gate_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start   [4];
   logic        abort   [4];
   logic [9:0]  exp_sig [4];
   logic [9:0]  dut_out [4];
   logic [17:0] dut_in  [4];
   logic        busy    [4];
   logic        done    [4];
   logic        pass    [4];
   logic [9:0]  sig     [4];
   logic [15:0] pcnt    [4];
   logic [9:0]  gkey;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_done [4] = '{0, 0, 0, 0};

   typedef struct {
      int          inst;
      logic [9:0]  sig;
      logic        pf;
      logic [17:0] last;
      int          t0;
   } exp_t;

   exp_t        sbq [$];
   logic [17:0] vq  [$];
   int          vk = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic int np(int k);
      case (k)
         0: return 12;
         1: return 1;
         2: return 3;
         default: return 40;
      endcase
   endfunction

   function automatic int sp(int k);
      return (k == 3) ? 3 : 1;
   endfunction

   function automatic logic [17:0] eff_seed(int k);
      logic [17:0] raw;
      raw = (k == 3) ? 18'h00000 : 18'h00001;
      return (raw == 18'h0) ? 18'h00001 : raw;
   endfunction

   function automatic logic [17:0] lfsr_nxt(logic [17:0] v);
      return {v[16:0], v[17] ^ v[10]};
   endfunction

   function automatic logic [9:0] misr_nxt(logic [9:0] m, logic [9:0] d);
      return {m[8:0], m[9] ^ m[6]} ^ d;
   endfunction

   function automatic logic [9:0] gate_model(int k, logic [17:0] v, logic [9:0] key);
      if (k == 3) return v[9:0] ^ v[17:8] ^ key;
      return v[9:0];
   endfunction

   function automatic logic [17:0] model_vec(int k, int n);
      logic [17:0] v;
      v = eff_seed(k);
      for (int i = 0; i < n; i++) v = lfsr_nxt(v);
      return v;
   endfunction

   function automatic logic [9:0] model_sig(int k, int n, logic [9:0] key);
      logic [17:0] v;
      logic [9:0]  m;
      v = eff_seed(k);
      m = '0;
      for (int i = 0; i < n; i++) begin
         m = misr_nxt(m, gate_model(k, v, key));
         v = lfsr_nxt(v);
      end
      return m;
   endfunction

   // ---------------- DUTs ----------------
   for (genvar g = 0; g < 4; g++) begin : g_dut
      assign dut_out[g] = gate_model(g, dut_in[g], gkey);
      gate_bist_ctrl #(
         .N_PATTERNS ((g == 0) ? 12 : (g == 1) ? 1 : (g == 2) ? 3 : 40),
         .SETTLE     ((g == 3) ? 3 : 1),
         .LFSR_SEED  ((g == 3) ? 18'h00000 : 18'h00001)
      ) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_start     (start[g]),
         .i_abort     (abort[g]),
         .i_exp_sig   (exp_sig[g]),
         .i_dut_out   (dut_out[g]),
         .o_dut_in    (dut_in[g]),
         .o_busy      (busy[g]),
         .o_done      (done[g]),
         .o_pass      (pass[g]),
         .o_signature (sig[g]),
         .o_pat_cnt   (pcnt[g])
      );
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // ---------------- monitors ----------------
   bit done_q [4];

   always @(negedge clk) begin : mon_done
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (done[k] === 1'b1 && !done_q[k]) begin
            n_done[k]++;
            if (sbq.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_done inst=%0d actual=done required=no pending run", k);
            end else begin
               e = sbq.pop_front();
               chk("done_inst", k, e.inst);
               chk("done_sig", sig[k], e.sig);
               chk("done_pass", pass[k], e.pf);
               chk("done_pat_cnt", pcnt[k], np(k));
               chk("done_last_vec", dut_in[k], e.last);
               // counted with the start-sampling edge as edge 1
               chk("done_edges", cyc - e.t0 + 1, np(k) * (sp(k) + 1) + 1);
            end
         end
         done_q[k] = (done[k] === 1'b1);
      end
   end

   logic [17:0] prev_in   = '0;
   bit          prev_busy = 1'b0;
   int          hold      = 0;

   always @(negedge clk) begin : mon_vec
      if (busy[vk] === 1'b1 && dut_in[vk] !== prev_in) begin
         if (prev_busy) chk("vec_hold", hold, sp(vk) + 1);
         if (vq.size() > 0) chk("vec_value", dut_in[vk], vq.pop_front());
         hold = 1;
      end else begin
         hold++;
      end
      prev_in   = dut_in[vk];
      prev_busy = (busy[vk] === 1'b1);
   end

   // ---------------- stimulus ----------------
   task automatic push_vecs(int k);
      for (int i = 0; i < np(k); i++) vq.push_back(model_vec(k, i));
   endtask

   // Returns on the negedge right after the start-sampling edge.
   task automatic run_start(int k, logic [9:0] ev, bit push);
      logic [9:0] s;
      @(negedge clk);
      start[k]   = 1'b1;
      exp_sig[k] = ev;
      @(negedge clk);
      start[k] = 1'b0;
      if (push) begin
         s = model_sig(k, np(k), gkey);
         sbq.push_back('{k, s, (s == ev), model_vec(k, np(k) - 1), cyc});
      end
   endtask

   task automatic wait_done(int k);
      int c0;
      int budget;
      c0 = n_done[k];
      budget = np(k) * (sp(k) + 1) + 20;
      for (int i = 0; i < budget && n_done[k] == c0; i++) @(negedge clk);
      chk("done_within_budget", (n_done[k] != c0), 1);
   endtask

   task automatic chk_zero(int k, string tag);
      chk({tag, "_busy"}, busy[k], 0);
      chk({tag, "_done"}, done[k], 0);
      chk({tag, "_pass"}, pass[k], 0);
      chk({tag, "_dut_in"}, dut_in[k], 0);
      chk({tag, "_sig"}, sig[k], 0);
      chk({tag, "_pat_cnt"}, pcnt[k], 0);
   endtask

   initial begin : watchdog
      repeat (30000) @(posedge clk);
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [9:0]  good;
      logic [9:0]  ev;
      int unsigned ka;
      int unsigned mode;

      rst  = 1'b1;
      gkey = '0;
      for (int i = 0; i < 4; i++) begin
         start[i]   = 1'b0;
         abort[i]   = 1'b0;
         exp_sig[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) chk_zero(k, "reset");
      rst = 1'b0;

      // sequence: 0x00001, 0x00002 ... 0x00400, 0x00801, each held 2 cycles
      push_vecs(0);
      run_start(0, model_sig(0, 12, '0), 1'b1);
      wait_done(0);
      chk("seq_vectors_consumed", vq.size(), 0);

      // restart from DONE, then a stray start mid-run
      push_vecs(0);
      run_start(0, 10'h3ff, 1'b1);
      chk("restart_done_drop", done[0], 0);
      chk("restart_busy", busy[0], 1);
      repeat ($urandom_range(1, 15)) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0);
      chk("stray_vectors_consumed", vq.size(), 0);

      // abort during the 5th SETTLE
      push_vecs(0);
      run_start(0, '0, 1'b0);
      for (int i = 0; i < 50 && pcnt[0] != 16'd4; i++) @(negedge clk);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort_busy", busy[0], 0);
      chk("abort_done", done[0], 0);
      chk("abort_dut_in", dut_in[0], 0);
      chk("abort_pat_cnt", pcnt[0], 4);
      chk("abort_sig", sig[0], model_sig(0, 4, '0));
      vq.delete();
      push_vecs(0);
      run_start(0, model_sig(0, 12, '0), 1'b1);
      chk("abort_restart_seed", dut_in[0], 18'h00001);
      chk("abort_restart_pat_cnt", pcnt[0], 0);
      wait_done(0);

      // reset while in CAPTURE of the 4th vector
      run_start(0, '0, 1'b0);
      repeat (7) @(negedge clk);
      chk("pre_rst_pat_cnt", pcnt[0], 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero(0, "midrun_rst");

      // start and abort together in IDLE
      start[0] = 1'b1;
      abort[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      abort[0] = 1'b0;
      chk("start_abort_busy", busy[0], 0);
      chk("start_abort_dut_in", dut_in[0], 0);
      repeat (3) @(negedge clk);
      chk("start_abort_idle_busy", busy[0], 0);
      chk("start_abort_idle_done", done[0], 0);

      // single-vector signatures
      run_start(1, 10'h001, 1'b1);
      wait_done(1);
      chk("one_vec_sig", sig[1], 10'h001);
      chk("one_vec_pass", pass[1], 1);
      run_start(1, 10'h002, 1'b1);
      chk("one_vec_restart_done", done[1], 0);
      wait_done(1);
      chk("one_vec_sig_again", sig[1], 10'h001);
      chk("one_vec_fail", pass[1], 0);

      // two and three vectors
      run_start(2, 10'h004, 1'b1);
      for (int i = 0; i < 20 && pcnt[2] != 16'd2; i++) @(negedge clk);
      chk("two_vec_sig", sig[2], 10'h000);
      wait_done(2);
      chk("three_vec_sig", sig[2], 10'h004);
      chk("three_vec_pass", pass[2], 1);

      // randomized runs on the keyed gate model, zero seed parameter
      vk = 3;
      for (int r = 0; r < 8; r++) begin
         gkey = 10'($urandom);
         good = model_sig(3, 40, gkey);
         ev   = ($urandom_range(0, 1) == 1) ? good : 10'($urandom);
         mode = $urandom_range(0, 2);
         push_vecs(3);
         if (mode == 2) begin
            run_start(3, ev, 1'b0);
            chk("rnd_seed", dut_in[3], 18'h00001);
            ka = $urandom_range(0, 159);
            repeat (ka) @(negedge clk);
            abort[3] = 1'b1;
            @(negedge clk);
            abort[3] = 1'b0;
            chk("rnd_abort_pat_cnt", pcnt[3], ka / 4);
            chk("rnd_abort_sig", sig[3], model_sig(3, int'(ka / 4), gkey));
            chk("rnd_abort_busy", busy[3], 0);
            chk("rnd_abort_dut_in", dut_in[3], 0);
            vq.delete();
         end else begin
            run_start(3, ev, 1'b1);
            chk("rnd_seed", dut_in[3], 18'h00001);
            if (mode == 1) begin
               repeat ($urandom_range(1, 150)) @(negedge clk);
               start[3] = 1'b1;
               @(negedge clk);
               start[3] = 1'b0;
            end
            wait_done(3);
            chk("rnd_vectors_consumed", vq.size(), 0);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
